// File: rtl/multicore_out_sched_pkg.sv
// Shared constants and types for the multicore start-up sequencer and output scheduler.
package multicore_pkg;
    localparam int N_CORES     = 26;
    localparam int DATA_W      = 31;
    localparam int EN_W        = 4;
    localparam int STAGGER_CYC = 17;
    localparam int SRC_W       = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam int CNT_W       = (STAGGER_CYC > 1) ? $clog2(STAGGER_CYC) : 1;

    typedef enum logic {
        SEQ_RELEASE,
        SEQ_DONE
    } seq_state_e;
endpackage

// File: rtl/multicore_out_sched_if.sv
// Core-side request bus plus the registered result stream of the scheduler.
interface multicore_out_sched_if;
    import multicore_pkg::*;

    logic [N_CORES-1:0]        core_rst;
    logic [N_CORES*DATA_W-1:0] core_data;
    logic [N_CORES*EN_W-1:0]   core_en;
    logic [N_CORES-1:0]        core_ack;
    logic [DATA_W-1:0]         out_data;
    logic [EN_W-1:0]           out_en;
    logic [SRC_W-1:0]          out_src;
    logic                      out_valid;
    logic                      out_ready;
    logic                      seq_done;

    modport master (
        output core_rst, core_ack, out_data, out_en, out_src, out_valid, seq_done,
        input  core_data, core_en, out_ready
    );

    modport slave (
        input  core_rst, core_ack, out_data, out_en, out_src, out_valid, seq_done,
        output core_data, core_en, out_ready
    );
endinterface

// File: rtl/multicore_out_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module rr_arbiter
    import multicore_pkg::*;
#(
    parameter int N = N_CORES,
    parameter int W = SRC_W
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o,
    output logic         any_o
);
    int j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N) j = j - N;
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = W'(j);
            end
        end
    end
endmodule

// File: rtl/multicore_out_sched.sv
// Staggered per-core reset release followed by round-robin sharing of one
// registered result stage under valid/ready.
module multicore_out_sched
    import multicore_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 restart,
    multicore_out_sched_if.master bus
);
    seq_state_e         state_q;
    logic [SRC_W-1:0]   idx_q, ptr_q, ptr_d, win_idx;
    logic [CNT_W-1:0]   cnt_q;
    logic [N_CORES-1:0] core_rst_q, req, gnt;
    logic               seq_done_q, any_gnt, capture;
    logic [DATA_W-1:0]  out_data_q;
    logic [EN_W-1:0]    out_en_q;
    logic [SRC_W-1:0]   out_src_q;
    logic               out_valid_q;

    for (genvar i = 0; i < N_CORES; i++) begin : g_req
        assign req[i] = !core_rst_q[i] && (bus.core_en[i*EN_W +: EN_W] != '0);
    end

    rr_arbiter #(.N(N_CORES), .W(SRC_W)) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (win_idx),
        .any_o (any_gnt)
    );

    // restart outranks a pending capture: nothing is acked on that cycle
    assign capture = any_gnt && (!out_valid_q || bus.out_ready) && !restart;
    assign ptr_d   = (win_idx == SRC_W'(N_CORES-1)) ? '0 : win_idx + 1'b1;

    assign bus.core_ack  = capture ? gnt : '0;
    assign bus.core_rst  = core_rst_q;
    assign bus.seq_done  = seq_done_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_en    = out_en_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_valid = out_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SEQ_RELEASE;
            idx_q      <= '0;
            cnt_q      <= '0;
            core_rst_q <= '1;
            seq_done_q <= 1'b0;
        end else if (restart) begin
            state_q    <= SEQ_RELEASE;
            idx_q      <= '0;
            cnt_q      <= '0;
            core_rst_q <= '1;
            seq_done_q <= 1'b0;
        end else begin
            case (state_q)
                SEQ_RELEASE: begin
                    // first cycle of each stage releases that stage's core
                    if (cnt_q == '0) core_rst_q[idx_q] <= 1'b0;
                    if (cnt_q == CNT_W'(STAGGER_CYC-1)) begin
                        cnt_q <= '0;
                        if (idx_q == SRC_W'(N_CORES-1)) state_q <= SEQ_DONE;
                        else                            idx_q   <= idx_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SEQ_DONE: seq_done_q <= 1'b1;
                default:  state_q    <= SEQ_RELEASE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            out_data_q  <= '0;
            out_en_q    <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
        end else if (restart) begin
            out_valid_q <= 1'b0;
        end else if (capture) begin
            out_data_q  <= bus.core_data[int'(win_idx)*DATA_W +: DATA_W];
            out_en_q    <= bus.core_en[int'(win_idx)*EN_W +: EN_W];
            out_src_q   <= win_idx;
            out_valid_q <= 1'b1;
            ptr_q       <= ptr_d;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_multicore_out_sched.sv
// Randomized bench for multicore_out_sched with a queue-free behavioural model
// of release timing and round-robin capture.
module tb_multicore_out_sched;
    import multicore_pkg::*;

    logic clk, rst_n, restart;
    multicore_out_sched_if bus();

    multicore_out_sched dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] dat [N_CORES];
    logic [EN_W-1:0]   en  [N_CORES];

    always_comb begin
        bus.core_data = '0;
        bus.core_en   = '0;
        for (int i = 0; i < N_CORES; i++) begin
            bus.core_data[i*DATA_W +: DATA_W] = dat[i];
            bus.core_en[i*EN_W +: EN_W]       = en[i];
        end
    end

    // edges since the release sequence (re)started
    int seq_edges = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       seq_edges <= 0;
        else if (restart) seq_edges <= 0;
        else              seq_edges <= seq_edges + 1;
    end

    int total = 0, bad = 0;

    int                 m_ptr, exp_win;
    logic               m_valid, exp_cap;
    logic [DATA_W-1:0]  m_data;
    logic [EN_W-1:0]    m_en;
    logic [SRC_W-1:0]   m_src;
    logic [N_CORES-1:0] exp_ack;

    function automatic logic [N_CORES-1:0] exp_rst();
        logic [N_CORES-1:0] r;
        for (int k = 0; k < N_CORES; k++) r[k] = !(seq_edges > k*STAGGER_CYC);
        return r;
    endfunction

    function automatic logic exp_done();
        return seq_edges > N_CORES*STAGGER_CYC;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_valid = 1'b0; m_data = '0; m_en = '0; m_src = '0;
    endtask

    task automatic predict();
        exp_ack = '0;
        exp_win = -1;
        for (int k = 0; k < N_CORES; k++) begin
            int j;
            j = (m_ptr + k) % N_CORES;
            if (exp_win < 0 && rst_n && seq_edges > j*STAGGER_CYC && en[j] != '0) exp_win = j;
        end
        exp_cap = (exp_win >= 0) && (!m_valid || bus.out_ready) && !restart;
        if (exp_cap) exp_ack[exp_win] = 1'b1;
    endtask

    task automatic commit();
        if (restart) m_valid = 1'b0;
        else if (exp_cap) begin
            m_valid = 1'b1;
            m_data  = dat[exp_win];
            m_en    = en[exp_win];
            m_src   = SRC_W'(exp_win);
            m_ptr   = (exp_win + 1) % N_CORES;
            en[exp_win] = '0;
        end else if (m_valid && bus.out_ready) m_valid = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < N_CORES; i++)
            if (en[i] == '0 && $urandom_range(0, 2) == 0) begin
                dat[i] = DATA_W'($urandom);
                en[i]  = EN_W'($urandom_range(0, 15));
            end
        bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N_CORES; i++) begin dat[i] = '0; en[i] = '0; end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; restart = 1'b0; bus.out_ready = 1'b1;
        clear_reqs();
        en[5] = 4'h1; dat[5] = 31'h1234567;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.core_rst !== '1 || bus.core_ack !== '0 || bus.out_valid !== 1'b0 ||
            bus.out_data !== '0 || bus.out_en !== '0 || bus.out_src !== '0 || bus.seq_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got rst=%h ack=%h v=%0b d=%h e=%h s=%0d done=%0b", bus.core_rst,
                     bus.core_ack, bus.out_valid, bus.out_data, bus.out_en, bus.out_src, bus.seq_done);
        end
    endtask

    task automatic test_release_gating();
        rst_n = 1'b1;
        for (int e = 0; e < 450; e++) begin
            @(negedge clk); predict();
            total++; if (bus.core_ack !== exp_ack) begin bad++; $display("FAIL rel_ack got=%h exp=%h", bus.core_ack, exp_ack); end
            @(posedge clk); #1; commit();
            total++;
            if (bus.out_valid !== m_valid || (m_valid && {bus.out_data, bus.out_en, bus.out_src} !== {m_data, m_en, m_src})) begin
                bad++; $display("FAIL rel_out got v=%0b s=%0d d=%h exp v=%0b s=%0d d=%h", bus.out_valid, bus.out_src, bus.out_data, m_valid, m_src, m_data);
            end
            total++;
            if (bus.core_rst !== exp_rst() || bus.seq_done !== exp_done()) begin
                bad++; $display("FAIL rel_seq edge=%0d got rst=%h done=%0b exp rst=%h done=%0b", e, bus.core_rst, bus.seq_done, exp_rst(), exp_done());
            end
            if (e == 0) begin
                total++; if (bus.core_rst[1:0] !== 2'b10) begin bad++; $display("FAIL rel_edge0 got=%b exp=10", bus.core_rst[1:0]); end
            end
            if (e == 16 || e == 17 || e == 424 || e == 425) begin
                total++;
                if (bus.core_rst[(e+1)/STAGGER_CYC] !== (e % STAGGER_CYC == 16 ? 1'b1 : 1'b0)) begin
                    bad++; $display("FAIL rel_stagger edge=%0d core=%0d got=%b", e, (e+1)/STAGGER_CYC, bus.core_rst[(e+1)/STAGGER_CYC]);
                end
            end
            if (e == 441 || e == 442) begin
                total++; if (bus.seq_done !== (e == 442)) begin bad++; $display("FAIL rel_done edge=%0d got=%b", e, bus.seq_done); end
            end
            if (e == 85) begin
                total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL gate_early got v=%b exp v=0", bus.out_valid); end
            end
            if (e == 86) begin
                total++; if (bus.out_valid !== 1'b1 || bus.out_src !== 5'd5) begin bad++; $display("FAIL gate_capture got v=%b s=%0d exp v=1 s=5", bus.out_valid, bus.out_src); end
            end
        end
    endtask

    task automatic test_fairness();
        logic [SRC_W-1:0] prev, nxt;
        prev = '0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            foreach (dat[i]) if ((i == 0 || i == 3 || i == 25) && en[i] == '0) begin
                dat[i] = DATA_W'($urandom); en[i] = EN_W'($urandom_range(1, 15));
            end
            @(negedge clk); predict();
            total++; if (bus.core_ack !== exp_ack) begin bad++; $display("FAIL fair_ack got=%h exp=%h", bus.core_ack, exp_ack); end
            @(posedge clk); #1; commit();
            total++;
            if (bus.out_valid !== m_valid || (m_valid && {bus.out_data, bus.out_en, bus.out_src} !== {m_data, m_en, m_src})) begin
                bad++; $display("FAIL fair_out got v=%0b s=%0d d=%h exp v=%0b s=%0d d=%h", bus.out_valid, bus.out_src, bus.out_data, m_valid, m_src, m_data);
            end
            nxt = (prev == 5'd0) ? 5'd3 : (prev == 5'd3) ? 5'd25 : 5'd0;
            if (c > 0) begin
                total++;
                if (bus.out_valid !== 1'b1 || bus.out_src !== nxt) begin
                    bad++; $display("FAIL fair_order got v=%b s=%0d exp v=1 s=%0d", bus.out_valid, bus.out_src, nxt);
                end
            end
            prev = bus.out_src;
        end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] hold_d;
        logic [SRC_W-1:0]  hold_s;
        int                nptr, want;
        clear_reqs();
        dat[2] = 31'h0000_0222; en[2] = 4'h2;
        dat[7] = 31'h7000_0777; en[7] = 4'h7;
        bus.out_ready = 1'b0;
        hold_d = bus.out_data; hold_s = bus.out_src;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); predict();
            total++; if (bus.core_ack !== '0) begin bad++; $display("FAIL bp_ack got=%h exp=0", bus.core_ack); end
            @(posedge clk); #1; commit();
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== hold_d || bus.out_src !== hold_s) begin
                bad++; $display("FAIL bp_hold got v=%b d=%h s=%0d exp v=1 d=%h s=%0d", bus.out_valid, bus.out_data, bus.out_src, hold_d, hold_s);
            end
        end
        nptr = (int'(hold_s) + 1) % N_CORES;
        want = (nptr <= 2 || nptr > 7) ? 2 : 7;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); predict();
            total++; if (bus.core_ack !== exp_ack) begin bad++; $display("FAIL bp_rel_ack got=%h exp=%h", bus.core_ack, exp_ack); end
            @(posedge clk); #1; commit();
            total++;
            if (bus.out_valid !== m_valid || (m_valid && {bus.out_data, bus.out_en, bus.out_src} !== {m_data, m_en, m_src})) begin
                bad++; $display("FAIL bp_out got v=%0b s=%0d d=%h exp v=%0b s=%0d d=%h", bus.out_valid, bus.out_src, bus.out_data, m_valid, m_src, m_data);
            end
            if (c == 0) begin
                total++; if (bus.out_src !== SRC_W'(want)) begin bad++; $display("FAIL bp_next got s=%0d exp s=%0d", bus.out_src, want); end
            end
        end
    endtask

    task automatic test_data_integrity();
        logic [DATA_W-1:0] ones;
        ones = '1;
        clear_reqs();
        dat[9] = ones; en[9] = 4'hA;
        bus.out_ready = 1'b1;
        @(negedge clk); predict();
        total++; if (bus.core_ack !== exp_ack) begin bad++; $display("FAIL data_ack got=%h exp=%h", bus.core_ack, exp_ack); end
        @(posedge clk); #1; commit();
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 31'h7FFFFFFF || bus.out_en !== 4'hA || bus.out_src !== 5'd9) begin
            bad++; $display("FAIL data_exact got v=%b d=%h e=%h s=%0d exp v=1 d=7fffffff e=a s=9", bus.out_valid, bus.out_data, bus.out_en, bus.out_src);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            fill_random();
            @(negedge clk); predict();
            total++; if (bus.core_ack !== exp_ack) begin bad++; $display("FAIL rnd_ack cyc=%0d got=%h exp=%h", c, bus.core_ack, exp_ack); end
            @(posedge clk); #1; commit();
            total++;
            if (bus.out_valid !== m_valid || (m_valid && {bus.out_data, bus.out_en, bus.out_src} !== {m_data, m_en, m_src})) begin
                bad++; $display("FAIL rnd_out cyc=%0d got v=%0b s=%0d d=%h e=%h exp v=%0b s=%0d d=%h e=%h", c, bus.out_valid, bus.out_src, bus.out_data, bus.out_en, m_valid, m_src, m_data, m_en);
            end
        end
    endtask

    task automatic test_restart();
        for (int c = 0; c < 70; c++) begin
            fill_random();
            bus.out_ready = 1'b1;
            restart = (c == 5);
            @(negedge clk); predict();
            total++; if (bus.core_ack !== exp_ack) begin bad++; $display("FAIL rst_ack cyc=%0d got=%h exp=%h", c, bus.core_ack, exp_ack); end
            @(posedge clk); #1; commit();
            restart = 1'b0;
            total++;
            if (bus.out_valid !== m_valid || (m_valid && {bus.out_data, bus.out_en, bus.out_src} !== {m_data, m_en, m_src})) begin
                bad++; $display("FAIL rst_out cyc=%0d got v=%0b s=%0d exp v=%0b s=%0d", c, bus.out_valid, bus.out_src, m_valid, m_src);
            end
            total++;
            if (bus.core_rst !== exp_rst() || bus.seq_done !== exp_done()) begin
                bad++; $display("FAIL rst_seq cyc=%0d got rst=%h done=%0b exp rst=%h done=%0b", c, bus.core_rst, bus.seq_done, exp_rst(), exp_done());
            end
            if (c == 5) begin
                total++;
                if (bus.core_rst !== '1 || bus.out_valid !== 1'b0 || bus.seq_done !== 1'b0) begin
                    bad++; $display("FAIL rst_flush got rst=%h v=%b done=%b exp rst=all1 v=0 done=0", bus.core_rst, bus.out_valid, bus.seq_done);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < N_CORES; i++) if (en[i] == '0) begin dat[i] = DATA_W'($urandom); en[i] = 4'h3; end
            bus.out_ready = 1'b1;
            @(negedge clk); predict();
            @(posedge clk); #1; commit();
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (bus.core_rst !== '1 || bus.core_ack !== '0 || bus.out_valid !== 1'b0 || bus.out_data !== '0 ||
            bus.out_en !== '0 || bus.out_src !== '0 || bus.seq_done !== 1'b0) begin
            bad++; $display("FAIL async_rst got rst=%h ack=%h v=%b d=%h e=%h s=%0d done=%b", bus.core_rst,
                            bus.core_ack, bus.out_valid, bus.out_data, bus.out_en, bus.out_src, bus.seq_done);
        end
        model_reset();
        clear_reqs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < 2; i++) if (en[i] == '0) begin dat[i] = DATA_W'($urandom); en[i] = 4'h5; end
            @(negedge clk); predict();
            total++; if (bus.core_ack !== exp_ack) begin bad++; $display("FAIL ar_ack cyc=%0d got=%h exp=%h", c, bus.core_ack, exp_ack); end
            @(posedge clk); #1; commit();
            total++;
            if (bus.out_valid !== m_valid || (m_valid && {bus.out_data, bus.out_en, bus.out_src} !== {m_data, m_en, m_src})) begin
                bad++; $display("FAIL ar_out cyc=%0d got v=%0b s=%0d exp v=%0b s=%0d", c, bus.out_valid, bus.out_src, m_valid, m_src);
            end
        end
    endtask

    initial begin
        test_reset();
        test_release_gating();
        test_fairness();
        test_backpressure();
        test_data_integrity();
        test_random();
        test_restart();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicore_out_sched.md
# multicore_out_sched

Start-up sequencer and output scheduler for the multicore array of `rede` cores. It releases each core's reset in a fixed staggered order, then shares the single result bus among all cores with round-robin arbitration. It registers the winning core's data and enable code into one output stage under a valid/ready handshake. It replaces first-match priority muxing and free-running reset release at the top of the multicore design.

## Interface
- `N_CORES`, default 26: number of cores.
- `DATA_W`, default 31: core result width, signed.
- `EN_W`, default 4: core enable/code width.
- `STAGGER_CYC`, default 17: cycles per release stage.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `restart` in 1: synchronous pulse that re-runs the release sequence.
- `core_rst` out N_CORES: per-core reset, active-high, to core `rst`.
- `core_data` in N_CORES*DATA_W: flattened core results; core i at [i*DATA_W +: DATA_W].
- `core_en` in N_CORES*EN_W: flattened core enable codes; nonzero means request.
- `core_ack` out N_CORES: one-hot; core's item captured this cycle.
- `out_data` out DATA_W: registered signed result.
- `out_en` out EN_W: registered enable code of that result.
- `out_src` out 5: index of the source core, sized $clog2(N_CORES).
- `out_valid` out 1: output register holds an item.
- `out_ready` in 1: downstream accepts when valid & ready.
- `seq_done` out 1: all cores released.

## Operation
- Sequencer FSM states:
  - RELEASE(idx, cnt):
    - On entry to a stage, `core_rst[idx]` clears.
    - `cnt` counts 0..STAGGER_CYC-1.
    - At STAGGER_CYC-1, `idx` increments and `cnt` returns to 0.
    - After idx = N_CORES-1 completes, go to DONE.
  - DONE: `seq_done` = 1. Stay until `restart`.
- `restart` in any state:
  - Next edge: all `core_rst` = 1, idx = 0, cnt = 0, `seq_done` = 0.
  - State returns to RELEASE.
  - The output register is flushed: `out_valid` = 0.
- Eligible requester i: `core_rst[i]` = 0 and core_en[i] != 0.
- Round-robin:
  - Search starts at `ptr`, wraps N_CORES-1 → 0.
  - The first eligible core wins.
  - After a grant, `ptr` = winner+1 mod N_CORES.
  - No grant means `ptr` is unchanged.
- Capture:
  - Condition: a winner exists and (!out_valid || out_ready).
  - Same edge: load `out_data`, `out_en`, `out_src`; set `out_valid` = 1.
  - `core_ack[winner]` is combinational, high during the capture cycle only.
- Each core holds its data and en until it is acked. Ungranted requests wait; nothing is dropped.
- With no winner and out_valid & out_ready, `out_valid` clears.
- Data passes unmodified: no sign or width change; `out_data` = core_data slice bit-exact.
- `restart` and a capture in the same cycle: `restart` wins. No ack, no capture.

## Timing
- Reset values:
  - `core_rst` all 1.
  - `core_ack` 0.
  - `out_data` 0, `out_en` 0, `out_src` 0.
  - `out_valid` 0.
  - `seq_done` 0.
  - `ptr` 0; state RELEASE with idx 0, cnt 0.
- Core release times, counting the first rising edge after `rst_n` rises as edge 0:
  - `core_rst[0]` falls at edge 0.
  - `core_rst[k]` falls at edge k*STAGGER_CYC.
  - `seq_done` rises at edge N_CORES*STAGGER_CYC (442 with defaults).
- Request-to-output latency is 1 cycle: request visible at edge t gives out_valid at edge t+1.
- Throughput: one item per cycle when `out_ready` is held high.
- While out_valid & !out_ready:
  - outputs are stable;
  - no ack, no pointer movement.
- `rst_n` asserted mid-operation: all registers go to reset values immediately, with no clock needed.

## Structure
- Shared package `multicore_pkg`:
  - `N_CORES`, `DATA_W`, `EN_W`, `STAGGER_CYC`, `SRC_W`;
  - sequencer state enum {SEQ_RELEASE, SEQ_DONE}.
- Sub-module `rr_arbiter`:
  - N-bit request vector plus pointer in;
  - one-hot grant, index and any-grant flag out;
  - purely combinational.
- The top contains the sequencer FSM, the pointer register and the output register.

## Test plan
- Reset release: deassert `rst_n`, hold `restart` = 0.
  - Expected: `core_rst[0]` low at edge 0, `core_rst[1]` at edge 17, `core_rst[25]` at edge 425.
  - Expected: `seq_done` high at edge 442.
- Gating: core 5 requests with en = 1 while `core_rst[5]` = 1.
  - Expected: no ack and no output until release.
  - Expected: captured 1 cycle after release with out_src = 5.
- Fairness: cores 0, 3 and 25 request continuously with distinct data; `out_ready` = 1.
  - Expected: out_src order 0, 3, 25, 0, 3, … one item per cycle.
  - Expected: pointer wraps 25 → 0.
- Backpressure: out_valid = 1 and `out_ready` = 0 for 10 cycles while cores 2 and 7 request.
  - Expected: out_data and out_src frozen; `core_ack` = 0.
  - Expected: on ready, the next capture goes to the core following the held source.
- Data integrity: core 9 drives -1 (all ones) with en = 4'hA.
  - Expected: out_data = 31'h7FFFFFFF, out_en = 4'hA, out_src = 9.
- Restart/reset mid-operation:
  - `restart` pulse during streaming: all `core_rst` high next edge, out_valid = 0, sequence reruns from core 0.
  - Async `rst_n` low between edges: outputs reset immediately.
